// File: rtl/mcu0_pkg.sv
// Shared definitions for the mcu0 memory bridge.
//   - MCU0_AW / MCU0_DW / MCU0_BW : byte-address width, core word width, RAM byte width
//   - bridge_state_e              : bridge FSM state, 3-bit encoding
package mcu0_pkg;

    localparam int MCU0_AW = 12;
    localparam int MCU0_DW = 16;
    localparam int MCU0_BW = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HI_REQ  = 3'd1,
        ST_HI_WAIT = 3'd2,
        ST_LO_REQ  = 3'd3,
        ST_LO_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_e;

endpackage

// File: rtl/mcu0_mem_bridge_if.sv
// Bus bundle between the mcu0 core, the bridge and the byte-wide RAM.
//   Core side : men, mw, maddr, mwdata (to bridge); mrdata, mready (from bridge)
//   RAM side  : ben, bwe, baddr, bwdata (from bridge); brdata (to bridge)
//   modport slave  : the bridge's view
//   modport master : the environment's view (core + RAM)
//
// Handshake: men is a request strobe that the bridge samples only while idle;
// a sampled men=1 accepts mw/maddr/mwdata in that same cycle. mready is a
// one-cycle completion pulse with no back-pressure; mrdata is valid while
// mready=1 and holds until the next read completes. On the RAM side, ben marks
// a one-cycle byte request, bwe is meaningful only with ben, and brdata is
// expected WAIT cycles after the ben cycle.
interface mcu0_mem_bridge_if #(
    parameter int AW = mcu0_pkg::MCU0_AW
);
    import mcu0_pkg::*;

    logic               men;
    logic               mw;
    logic [AW-1:0]      maddr;
    logic [MCU0_DW-1:0] mwdata;
    logic [MCU0_DW-1:0] mrdata;
    logic               mready;

    logic               ben;
    logic               bwe;
    logic [AW-1:0]      baddr;
    logic [MCU0_BW-1:0] bwdata;
    logic [MCU0_BW-1:0] brdata;

    modport slave (
        input  men, mw, maddr, mwdata, brdata,
        output mrdata, mready, ben, bwe, baddr, bwdata
    );

    modport master (
        output men, mw, maddr, mwdata, brdata,
        input  mrdata, mready, ben, bwe, baddr, bwdata
    );

endinterface

// File: rtl/mcu0_wait_cnt.sv
// 4-bit loadable down-counter that times RAM wait states.
//   clock : system clock
//   reset : asynchronous, active-low
//   load  : load val this cycle (takes priority over counting)
//   val   : load value (WAIT-1)
//   zero  : counter is at 0; it stops there until reloaded
module mcu0_wait_cnt (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] val,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= val;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mcu0_mem_bridge.sv
// Bridge from mcu0 16-bit word accesses to a byte-wide synchronous RAM.
// Each word access becomes two byte accesses, high byte at maddr and low byte
// at maddr+1 (big-endian, wrapping at 2^AW), each followed by WAIT cycles.
//   clock   : system clock
//   reset   : asynchronous, active-low; forces IDLE and clears all outputs
//   bus     : mcu0_mem_bridge_if.slave (core and RAM signals)
//   state_o : current FSM state, for observation
// Parameters: AW byte-address width, WAIT wait cycles per byte (1..15).
module mcu0_mem_bridge
    import mcu0_pkg::*;
#(
    parameter int AW   = MCU0_AW,
    parameter int WAIT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    mcu0_mem_bridge_if.slave      bus,
    output bridge_state_e         state_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

    bridge_state_e      state_q;
    logic               w_q;
    logic [AW-1:0]      addr_q;
    logic [MCU0_DW-1:0] wdata_q;
    logic [MCU0_BW-1:0] hi_q;
    logic [MCU0_DW-1:0] mrdata_q;
    logic               mready_q;
    logic               ben_q;
    logic               bwe_q;
    logic [AW-1:0]      baddr_q;
    logic [MCU0_BW-1:0] bwdata_q;

    logic cnt_load;
    logic cnt_zero;

    // The counter loads on the edge that leaves a request cycle, so it reads
    // zero on the last of the WAIT cycles that follow.
    assign cnt_load = (state_q == ST_HI_REQ) || (state_q == ST_LO_REQ);

    mcu0_wait_cnt u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .val   (WAIT_LOAD),
        .zero  (cnt_zero)
    );

    // Outputs are registered: the byte request is set up on the edge that
    // enters a *_REQ state, so ben is high exactly during that state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            w_q      <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hi_q     <= '0;
            mrdata_q <= '0;
            mready_q <= 1'b0;
            ben_q    <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
        end else begin
            mready_q <= 1'b0;
            ben_q    <= 1'b0;
            bwe_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.men) begin
                        w_q      <= bus.mw;
                        addr_q   <= bus.maddr;
                        wdata_q  <= bus.mwdata;
                        ben_q    <= 1'b1;
                        bwe_q    <= bus.mw;
                        baddr_q  <= bus.maddr;
                        bwdata_q <= bus.mwdata[15:8];
                        state_q  <= ST_HI_REQ;
                    end
                end
                ST_HI_REQ: begin
                    state_q <= ST_HI_WAIT;
                end
                ST_HI_WAIT: begin
                    if (cnt_zero) begin
                        if (!w_q) begin
                            hi_q <= bus.brdata;
                        end
                        ben_q    <= 1'b1;
                        bwe_q    <= w_q;
                        baddr_q  <= addr_q + AW'(1);   // wraps to 0 at the top
                        bwdata_q <= wdata_q[7:0];
                        state_q  <= ST_LO_REQ;
                    end
                end
                ST_LO_REQ: begin
                    state_q <= ST_LO_WAIT;
                end
                ST_LO_WAIT: begin
                    if (cnt_zero) begin
                        if (!w_q) begin
                            mrdata_q <= {hi_q, bus.brdata};
                        end
                        mready_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mrdata = mrdata_q;
    assign bus.mready = mready_q;
    assign bus.ben    = ben_q;
    assign bus.bwe    = bwe_q;
    assign bus.baddr  = baddr_q;
    assign bus.bwdata = bwdata_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mcu0_mem_bridge.sv
// Directed bench for mcu0_mem_bridge: one bridge built with WAIT=1 and one
// with WAIT=3, both attached to a shared byte RAM model whose read data
// appears WAIT cycles after the ben cycle.
module tb_mcu0_mem_bridge;
    import mcu0_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    mcu0_mem_bridge_if #(.AW(12)) b1 ();
    mcu0_mem_bridge_if #(.AW(12)) b3 ();
    bridge_state_e st1;
    bridge_state_e st3;

    mcu0_mem_bridge #(.AW(12), .WAIT(1)) dut1 (
        .clock   (clock),
        .reset   (reset),
        .bus     (b1),
        .state_o (st1)
    );

    mcu0_mem_bridge #(.AW(12), .WAIT(3)) dut3 (
        .clock   (clock),
        .reset   (reset),
        .bus     (b3),
        .state_o (st3)
    );

    // ---------------- byte RAM model ----------------
    logic [7:0]  mem [0:4095];
    logic        clr;
    logic        pk_en;
    logic [11:0] pk_addr;
    logic [7:0]  pk_data;
    logic [7:0]  p1;
    logic [7:0]  p3 [0:2];

    assign b1.brdata = p1;
    assign b3.brdata = p3[2];

    always @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end
        if (pk_en) mem[pk_addr] <= pk_data;
        if (b1.ben && b1.bwe) mem[b1.baddr] <= b1.bwdata;
        if (b3.ben && b3.bwe) mem[b3.baddr] <= b3.bwdata;
        p1    <= (b1.ben && !b1.bwe) ? mem[b1.baddr] : 8'h00;
        p3[0] <= (b3.ben && !b3.bwe) ? mem[b3.baddr] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pk_en   = 1'b1;
        pk_addr = a;
        pk_data = d;
        tick();
        pk_en   = 1'b0;
    endtask

    // One access on the WAIT=1 bridge. exp_rd is the mrdata expected at the
    // completion pulse (for a write, the unchanged previous read value).
    task automatic access1(input string tag, input logic w, input logic [11:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd);
        logic [11:0] a_lo;
        int ben_n;
        int rdy_n;
        int rdy_at;
        a_lo   = a + 12'd1;
        ben_n  = 0;
        rdy_n  = 0;
        rdy_at = -1;
        exp_q.push_back(exp_rd);
        b1.men    = 1'b1;
        b1.mw     = w;
        b1.maddr  = a;
        b1.mwdata = d;
        tick();                      // just after E0
        b1.men    = 1'b0;
        b1.mw     = ~w;
        b1.maddr  = ~a;
        b1.mwdata = ~d;
        for (int n = 0; n < 8; n++) begin
            if (b1.ben) begin
                ben_n++;
                chk({tag, ".ben_at"}, n, (ben_n == 1) ? 0 : 2);
                chk({tag, ".baddr"}, b1.baddr, (ben_n == 1) ? a : a_lo);
                chk({tag, ".bwe"}, b1.bwe, w);
                if (w) chk({tag, ".bwdata"}, b1.bwdata, (ben_n == 1) ? d[15:8] : d[7:0]);
            end
            if (b1.mready) begin
                rdy_n++;
                rdy_at = n;
                if (exp_q.size() > 0) chk({tag, ".mrdata"}, b1.mrdata, exp_q.pop_front());
            end
            tick();
        end
        chk({tag, ".ben_cycles"}, ben_n, 2);
        chk({tag, ".mready_pulses"}, rdy_n, 1);
        chk({tag, ".mready_edge"}, rdy_at, 4);
        chk({tag, ".mrdata_hold"}, b1.mrdata, exp_rd);
        chk({tag, ".idle"}, st1, ST_IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rdy_t[$];
        int ben_t[$];
        logic [11:0] ba[$];
        int exp_rdy[3];
        int exp_ben[6];
        logic [11:0] exp_ba[6];

        reset = 1'b0;
        clr = 1'b1;
        pk_en = 1'b0;
        pk_addr = '0;
        pk_data = '0;
        b1.men = 1'b0; b1.mw = 1'b0; b1.maddr = '0; b1.mwdata = '0;
        b3.men = 1'b0; b3.mw = 1'b0; b3.maddr = '0; b3.mwdata = '0;
        tick();
        clr = 1'b0;
        tick();

        // reset values on both builds
        chk("rst.mrdata1", b1.mrdata, 16'h0000);
        chk("rst.mready1", b1.mready, 1'b0);
        chk("rst.ben1",    b1.ben,    1'b0);
        chk("rst.bwe1",    b1.bwe,    1'b0);
        chk("rst.baddr1",  b1.baddr,  12'h000);
        chk("rst.bwdata1", b1.bwdata, 8'h00);
        chk("rst.state1",  st1,       ST_IDLE);
        chk("rst.mrdata3", b3.mrdata, 16'h0000);
        chk("rst.ben3",    b3.ben,    1'b0);
        chk("rst.state3",  st3,       ST_IDLE);
        reset = 1'b1;

        poke(12'h010, 8'h12); poke(12'h011, 8'h34);
        poke(12'h012, 8'h56); poke(12'h013, 8'h78);
        poke(12'h014, 8'h9A); poke(12'h015, 8'hBC);
        poke(12'hFFF, 8'h5A); poke(12'h000, 8'hA5);
        poke(12'h031, 8'h77);

        // 1. basic read
        access1("t1_rd010", 1'b0, 12'h010, 16'h0000, 16'h1234);

        // 2. write then read back; write leaves mrdata alone
        access1("t2_wr020", 1'b1, 12'h020, 16'hABCD, 16'h1234);
        chk("t2.mem020", mem[12'h020], 8'hAB);
        chk("t2.mem021", mem[12'h021], 8'hCD);
        access1("t2_rd020", 1'b0, 12'h020, 16'h0000, 16'hABCD);

        // 3. address wrap: low byte comes from 0x000
        access1("t3_rdFFF", 1'b0, 12'hFFF, 16'h0000, 16'h5AA5);

        // 4. men held high for three reads; maddr scrambled while busy
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        exp_q.push_back(16'h9ABC);
        b1.men = 1'b1; b1.mw = 1'b0; b1.maddr = 12'h010;
        tick();                      // just after E0
        for (int n = 0; n < 18; n++) begin
            if (b1.ben) begin
                ben_t.push_back(n);
                ba.push_back(b1.baddr);
            end
            if (b1.mready) begin
                rdy_t.push_back(n);
                if (exp_q.size() > 0) chk("t4.mrdata", b1.mrdata, exp_q.pop_front());
            end
            if (n == 0 || n == 6 || n == 12) b1.maddr = 12'hABC;
            if (n == 5)  b1.maddr = 12'h012;
            if (n == 11) b1.maddr = 12'h014;
            if (n == 12) b1.men = 1'b0;
            tick();
        end
        exp_rdy = '{4, 10, 16};
        exp_ben = '{0, 2, 6, 8, 12, 14};
        exp_ba  = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h014, 12'h015};
        chk("t4.mready_pulses", rdy_t.size(), 3);
        chk("t4.ben_cycles", ben_t.size(), 6);
        if (rdy_t.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t4.mready_edge", rdy_t[i], exp_rdy[i]);
        end
        if (ben_t.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t4.ben_edge", ben_t[i], exp_ben[i]);
                chk("t4.baddr", ba[i], exp_ba[i]);
            end
        end

        // 5. write aborted by reset. The RAM commits the low byte on the edge
        //    that closes LO_REQ, so reset lands inside LO_REQ to leave only
        //    the high byte written.
        b1.men = 1'b1; b1.mw = 1'b1; b1.maddr = 12'h030; b1.mwdata = 16'h1111;
        tick();                      // after E0: HI_REQ
        b1.men = 1'b0;
        tick();                      // after E1: HI_WAIT
        tick();                      // after E2: LO_REQ
        chk("t5.pre_state", st1, ST_LO_REQ);
        chk("t5.pre_ben", b1.ben, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5.async_mrdata", b1.mrdata, 16'h0000);
        chk("t5.async_mready", b1.mready, 1'b0);
        chk("t5.async_ben",    b1.ben,    1'b0);
        chk("t5.async_bwe",    b1.bwe,    1'b0);
        chk("t5.async_baddr",  b1.baddr,  12'h000);
        chk("t5.async_bwdata", b1.bwdata, 8'h00);
        chk("t5.async_state",  st1,       ST_IDLE);
        tick();
        tick();
        chk("t5.mem030", mem[12'h030], 8'h11);
        chk("t5.mem031", mem[12'h031], 8'h77);
        reset = 1'b1;
        tick();
        access1("t5_rd010", 1'b0, 12'h010, 16'h0000, 16'h1234);

        // 6. WAIT=3 build
        rdy_t.delete();
        ben_t.delete();
        ba.delete();
        b3.men = 1'b1; b3.mw = 1'b0; b3.maddr = 12'h010;
        tick();                      // just after E0
        b3.men = 1'b0;
        b3.maddr = 12'hABC;
        for (int n = 0; n < 12; n++) begin
            if (b3.ben) begin
                ben_t.push_back(n);
                ba.push_back(b3.baddr);
            end
            if (b3.mready) begin
                rdy_t.push_back(n);
                chk("t6.mrdata", b3.mrdata, 16'h1234);
            end
            tick();
        end
        chk("t6.mready_pulses", rdy_t.size(), 1);
        chk("t6.ben_cycles", ben_t.size(), 2);
        if (rdy_t.size() == 1) chk("t6.mready_edge", rdy_t[0], 8);
        if (ben_t.size() == 2) begin
            chk("t6.ben_edge_hi", ben_t[0], 0);
            chk("t6.ben_edge_lo", ben_t[1], 4);
            chk("t6.baddr_hi", ba[0], 12'h010);
            chk("t6.baddr_lo", ba[1], 12'h011);
        end
        chk("t6.mrdata_hold", b3.mrdata, 16'h1234);

        // ---------------- report ----------------
        chk("sb.queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
